// File: rtl/add_serial_feeder_if.sv
// ---------------------------------------------------------------------------
// add_serial_feeder_if
//   Handshake bundle between the operand producer / result consumer and the
//   add_serial feeder.
//   Operand channel : in_valid, in_ready, in_a[7:0], in_b[7:0]
//   Result channel  : res_valid, res_ready, res_sum[7:0]
//   master : producer/consumer side (drives operands, accepts results)
//   slave  : feeder side (accepts operands, drives results)
// ---------------------------------------------------------------------------
interface add_serial_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_sum;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_sum
  );
endinterface

// File: rtl/add_serial_feeder.sv
// ---------------------------------------------------------------------------
// add_serial_feeder
//   Operand sequencer for the 8-bit serial adder. Queues (a,b) pairs in a
//   small FIFO, launches one addition at a time (stable a/b, one-cycle en),
//   waits the adder's fixed latency, captures its output and offers it as a
//   valid/ready result. Results leave in operand order.
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   up_if      : slave side of the operand/result handshake bundle
//   add_en_o   : en pulse to the adder, one cycle per operation
//   add_a_o    : operand a to the adder, held from launch until capture
//   add_b_o    : operand b to the adder, held from launch until capture
//   add_out_i  : sum returned by the adder
//   busy_o     : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module add_serial_feeder #(
  parameter int DEPTH       = 4,
  parameter int ADD_LATENCY = 9
) (
  input  logic               clk,
  input  logic               rst,
  add_serial_feeder_if.slave up_if,
  output logic               add_en_o,
  output logic [7:0]         add_a_o,
  output logic [7:0]         add_b_o,
  input  logic [7:0]         add_out_i,
  output logic               busy_o
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(ADD_LATENCY) + 1;

  localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ADD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [15:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]  fcnt_q;

  logic               add_en_q;
  logic               busy_q;
  logic [7:0]         add_a_q, add_b_q;
  logic               res_valid_q;
  logic [7:0]         res_sum_q;

  logic               in_ready_s;
  logic               push_s;
  logic               pop_s;
  logic               res_pop_s;

  // in_ready depends on the stored count only, never on a same-cycle pop
  assign in_ready_s = (fcnt_q != FCNT_FULL);
  assign push_s     = up_if.in_valid & in_ready_s;
  assign res_pop_s  = res_valid_q & up_if.res_ready;

  // Next-state logic; pop_s marks the IDLE cycle that dequeues the head pair
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A launch needs the result slot empty now or emptied this cycle,
        // so CAPTURE can never overwrite an unconsumed result.
        if ((fcnt_q != {FCNT_W{1'b0}}) && (!res_valid_q || up_if.res_ready)) begin
          pop_s   = 1'b1;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // cnt_d is the incremented count; leaving when it reaches
        // ADD_LATENCY-1 places CAPTURE exactly ADD_LATENCY cycles after LAUNCH.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, latency counter and registered adder controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      add_en_q <= 1'b0;
      busy_q   <= 1'b0;
      add_a_q  <= 8'h00;
      add_b_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      add_en_q <= pop_s;
      busy_q   <= (state_d != S_IDLE);
      if (pop_s) begin
        add_a_q <= mem_q[rd_ptr_q][15:8];
        add_b_q <= mem_q[rd_ptr_q][7:0];
      end
    end
  end

  // FIFO pointers and occupancy; push plus pop leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      fcnt_q   <= {FCNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fcnt_q <= fcnt_q + FCNT_W'(1);
        2'b01:   fcnt_q <= fcnt_q - FCNT_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {up_if.in_a, up_if.in_b};
    end
  end

  // Result slot: capture sets it, consumer handshake clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= 8'h00;
    end else if (state_q == S_CAPTURE) begin
      res_valid_q <= 1'b1;
      res_sum_q   <= add_out_i;
    end else if (res_pop_s) begin
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= res_valid_q;
    end
  end

  assign up_if.in_ready  = in_ready_s;
  assign up_if.res_valid = res_valid_q;
  assign up_if.res_sum   = res_sum_q;
  assign add_en_o        = add_en_q;
  assign add_a_o         = add_a_q;
  assign add_b_o         = add_b_q;
  assign busy_o          = busy_q;

endmodule
